// File: rtl/xhdmiin_pkg.sv
// Shared TMDS word-aligner definitions: control tokens, lane state encoding, token matcher.
package xhdmiin_pkg;

  localparam logic [9:0] CTL00 = 10'h354;
  localparam logic [9:0] CTL01 = 10'h0AB;
  localparam logic [9:0] CTL10 = 10'h154;
  localparam logic [9:0] CTL11 = 10'h2AB;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lane_state_e;

  function automatic logic is_ctl_token(input logic [9:0] w);
    return (w == CTL00) || (w == CTL01) || (w == CTL10) || (w == CTL11);
  endfunction

endpackage

// File: rtl/xhdmiin_align_lane.sv
// One TMDS lane: sliding 2-word window, shift search, lock/loss FSM and registered output.
// XHDMIIN_WORDALIGN_BITREV_EN bit-reverses the incoming word ahead of the window.
module xhdmiin_align_lane
  import xhdmiin_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int TIMEOUT    = 2048,
  parameter int LOCK_COUNT = 8,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] aligned,
  output logic [SW-1:0]    shift,
  output logic             locked
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = $clog2(LOCK_COUNT + 1);

  logic [WIDTH-1:0]   w, prev, cand;
  logic [2*WIDTH-1:0] win;
  logic               tok;

`ifdef XHDMIIN_WORDALIGN_BITREV_EN
  always_comb begin
    w = '0;
    for (int i = 0; i < WIDTH; i++) w[i] = word[WIDTH-1-i];
  end
`else
  assign w = word;
`endif

  assign win  = {w, prev};
  assign cand = WIDTH'(win >> shift);

  generate
    if (WIDTH == 10) begin : g_tok10
      assign tok = is_ctl_token(cand);
    end else begin : g_tok_bad
      assign tok = 1'b0;
      $error("xhdmiin_align_lane: no token set defined for this WIDTH");
    end
  endgenerate

  lane_state_e   state, state_nx;
  logic [CW-1:0] tok_cnt, cnt_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [SW-1:0] shift_nx;
  logic          timer_last, cnt_last;

  assign timer_last = (timer == TW'(TIMEOUT - 1));
  assign cnt_last   = (tok_cnt == CW'(LOCK_COUNT - 1));

  // A token always beats a simultaneous timer expiry.
  always_comb begin
    state_nx = state;
    cnt_nx   = tok_cnt;
    timer_nx = timer;
    shift_nx = shift;
    if (ce) begin
      case (state)
        SEARCH: begin
          if (tok) begin
            timer_nx = '0;
            if (cnt_last) begin
              state_nx = LOCKED;
              cnt_nx   = '0;
            end else begin
              cnt_nx = tok_cnt + CW'(1);
            end
          end else begin
            cnt_nx = '0;
            if (timer_last) begin
              timer_nx = '0;
              shift_nx = (shift == SW'(WIDTH - 1)) ? '0 : shift + SW'(1);
            end else begin
              timer_nx = timer + TW'(1);
            end
          end
        end
        LOCKED: begin
          if (tok) begin
            timer_nx = '0;
          end else if (timer_last) begin
            state_nx = SEARCH;
            timer_nx = '0;
          end else begin
            timer_nx = timer + TW'(1);
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SEARCH;
      tok_cnt <= '0;
      timer   <= '0;
      shift   <= '0;
      prev    <= '0;
      aligned <= '0;
    end else begin
      state   <= state_nx;
      tok_cnt <= cnt_nx;
      timer   <= timer_nx;
      shift   <= shift_nx;
      if (ce) begin
        prev    <= w;
        aligned <= cand;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: rtl/xhdmiin_wordalign.sv
// Multi-lane TMDS word aligner: NCH independent lanes plus shared valid / all-locked flags.
// Optional bit reversal of input words via XHDMIIN_WORDALIGN_BITREV_EN (see lane).
module xhdmiin_wordalign #(
  parameter int NCH        = 3,
  parameter int WIDTH      = 10,
  parameter int TIMEOUT    = 2048,
  parameter int LOCK_COUNT = 8,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic [NCH*WIDTH-1:0] i_word,
  output logic [NCH*WIDTH-1:0] o_word,
  output logic                 o_valid,
  output logic [NCH*SW-1:0]    o_shift,
  output logic [NCH-1:0]       o_locked,
  output logic                 o_all_locked
);

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_lane
      xhdmiin_align_lane #(
        .WIDTH      (WIDTH),
        .TIMEOUT    (TIMEOUT),
        .LOCK_COUNT (LOCK_COUNT)
      ) u_lane (
        .clk     (i_clk),
        .rst     (i_reset),
        .ce      (i_ce),
        .word    (i_word[k*WIDTH +: WIDTH]),
        .aligned (o_word[k*WIDTH +: WIDTH]),
        .shift   (o_shift[k*SW +: SW]),
        .locked  (o_locked[k])
      );
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid      <= 1'b0;
      o_all_locked <= 1'b0;
    end else begin
      o_valid      <= i_ce;
      o_all_locked <= &o_locked;
    end
  end

endmodule

// File: tb/tb_xhdmiin_wordalign.sv
// Self-checking bench for xhdmiin_wordalign: constant tables, directed corner sequences,
// and randomized streams against a behavioural lane model.
module tb_xhdmiin_wordalign;

  localparam int NCH = 3;
  localparam int W   = 10;
  localparam int SW  = 4;
  localparam int TO  = 16;
  localparam int LC  = 8;

  logic              i_clk, i_reset, i_ce;
  logic [NCH*W-1:0]  i_word, o_word;
  logic              o_valid, o_all_locked;
  logic [NCH*SW-1:0] o_shift;
  logic [NCH-1:0]    o_locked;

  xhdmiin_wordalign #(.NCH(NCH), .WIDTH(W), .TIMEOUT(TO), .LOCK_COUNT(LC)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_word(i_word),
    .o_word(o_word), .o_valid(o_valid), .o_shift(o_shift),
    .o_locked(o_locked), .o_all_locked(o_all_locked)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_prev[NCH], m_shift[NCH], m_run[NCH], m_idle[NCH];
  bit         m_lock[NCH];
  logic [NCH*W-1:0] m_word;
  bit         m_valid, m_all;

  function automatic int rotl(int x, int r);
    return ((x << r) | (x >> (W - r))) & 1023;
  endfunction

  function automatic bit is_tok(int c);
    return (c == 'h354) || (c == 'h0AB) || (c == 'h154) || (c == 'h2AB);
  endfunction

  function automatic int lane_in(int x);
    int y = x;
`ifdef XHDMIIN_WORDALIGN_BITREV_EN
    y = 0;
    for (int i = 0; i < W; i++) if (x[i]) y |= 1 << (W - 1 - i);
`endif
    return y;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_prev[k] = 0; m_shift[k] = 0; m_run[k] = 0; m_idle[k] = 0; m_lock[k] = 0;
    end
    m_word = '0; m_valid = 0; m_all = 0;
  endtask

  task automatic model_step(input bit ce, input logic [NCH*W-1:0] w);
    bit all = 1;
    for (int k = 0; k < NCH; k++) all &= m_lock[k];
    m_all   = all;
    m_valid = ce;
    if (ce) begin
      for (int k = 0; k < NCH; k++) begin
        int cur, c;
        cur = lane_in(int'(w[k*W +: W]));
        c = (((cur << W) | m_prev[k]) >> m_shift[k]) & 1023;
        m_word[k*W +: W] = W'(c);
        m_prev[k] = cur;
        if (is_tok(c)) begin
          m_idle[k] = 0;
          if (!m_lock[k]) begin
            m_run[k]++;
            if (m_run[k] == LC) begin m_lock[k] = 1; m_run[k] = 0; end
          end
        end else begin
          m_run[k] = 0;
          m_idle[k]++;
          if (m_idle[k] == TO) begin
            m_idle[k] = 0;
            if (m_lock[k]) m_lock[k] = 0;
            else m_shift[k] = (m_shift[k] + 1) % W;
          end
        end
      end
    end
  endtask

  task automatic tick(input bit ce, input logic [NCH*W-1:0] w);
    logic [NCH*SW-1:0] es;
    logic [NCH-1:0]    el;
    i_ce   = ce;
    i_word = w;
    @(posedge i_clk);
    model_step(ce, w);
    @(negedge i_clk);
    for (int k = 0; k < NCH; k++) begin
      es[k*SW +: SW] = SW'(m_shift[k]);
      el[k] = m_lock[k];
    end
    chk("model_word", o_word, m_word);
    chk("model_valid", o_valid, m_valid);
    chk("model_shift", o_shift, es);
    chk("model_locked", o_locked, el);
    chk("model_all", o_all_locked, m_all);
  endtask

  task automatic feed(input int n, input logic [W-1:0] w);
    for (int i = 0; i < n; i++) tick(1'b1, {NCH{w}});
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_word"}, o_word, 0);
    chk({nm, "_valid"}, o_valid, 0);
    chk({nm, "_shift"}, o_shift, 0);
    chk({nm, "_locked"}, o_locked, 0);
    chk({nm, "_all"}, o_all_locked, 0);
  endtask

  // Asserted between edges: outputs must clear with no clock edge.
  task automatic do_reset();
    @(negedge i_clk);
    #2 i_reset = 1'b1;
    #1 check_zero("rst_async");
    @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();
  endtask

  task automatic misalign(input int r);
    int edges = 0;
    int last = 0;
    bit wrapped = 0;
    logic [W-1:0] w;
    do_reset();
    w = W'(rotl('h354, r));
    while (!o_locked[0] && edges < 400) begin
      feed(1, w);
      edges++;
      if (int'(o_shift[SW-1:0]) < last) wrapped = 1;
      last = int'(o_shift[SW-1:0]);
    end
    chk($sformatf("mis%0d_lock_edge", r), edges, 16 * r + LC);
    chk($sformatf("mis%0d_shift", r), o_shift[SW-1:0], r);
    chk($sformatf("mis%0d_nowrap", r), wrapped, 0);
    feed(1, w);
    chk($sformatf("mis%0d_word", r), o_word[W-1:0], 10'h354);
  endtask

  typedef struct {
    bit           ce;
    logic [W-1:0] w;
    logic [W-1:0] exp_word0;
    bit           exp_lock0;
    bit           exp_all;
    logic [SW-1:0] exp_shift0;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Aligned CTL00 stream: prev primed on word 1, tokens counted on words 2..9.
    for (int i = 0; i < 11; i++)
      tbl[i] = '{1'b1, 10'h354, (i == 0) ? 10'h000 : 10'h354, i >= 8, i >= 9, 4'd0};

    i_reset = 1'b1; i_ce = 1'b0; i_word = '0;
    #3 check_zero("rst_init");
    @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();

    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].ce, {NCH{tbl[i].w}});
      chk($sformatf("tbl%0d_word0", i), o_word[W-1:0], tbl[i].exp_word0);
      chk($sformatf("tbl%0d_lock0", i), o_locked[0], tbl[i].exp_lock0);
      chk($sformatf("tbl%0d_all", i), o_all_locked, tbl[i].exp_all);
      chk($sformatf("tbl%0d_shift0", i), o_shift[SW-1:0], tbl[i].exp_shift0);
    end

    // Broken run: a data word in the middle resets the token count.
    do_reset();
    feed(7, 10'h354); feed(1, 10'h1F0); feed(8, 10'h354);
    chk("broken_not_yet", o_locked, 3'b000);
    feed(1, 10'h354);
    chk("broken_locked", o_locked, 3'b111);

    // Loss of lock with TIMEOUT=16.
    do_reset();
    feed(9, 10'h354);
    chk("loss_locked", o_locked, 3'b111);
    feed(15, 10'h1F0); feed(1, 10'h354);
    chk("loss_t15", o_locked, 3'b111);
    feed(1, 10'h1F0);
    chk("loss_tok_saves", o_locked, 3'b111);
    feed(15, 10'h1F0);
    chk("loss_15data", o_locked, 3'b111);
    feed(1, 10'h1F0);
    chk("loss_drop", o_locked, 3'b000);
    chk("loss_all_lag", o_all_locked, 1'b1);
    chk("loss_shift", o_shift, 0);
    feed(1, 10'h1F0);
    chk("loss_all_drop", o_all_locked, 1'b0);

    misalign(3);
    misalign(9);

    // i_ce 1-of-3: lock needs 9 strobed words regardless of idle cycles.
    do_reset();
    begin
      int ce_edges = 0;
      for (int i = 0; i < 100 && !o_locked[0]; i++) begin
        bit ce = (i % 3 == 0);
        tick(ce, {NCH{10'h354}});
        chk("ce_valid", o_valid, ce);
        if (ce) ce_edges++;
      end
      chk("ce_lock_edges", ce_edges, 9);
    end

    // Randomized segments against the model.
    do_reset();
    for (int seg = 0; seg < 40; seg++) begin
      int rot[NCH];
      int mode[NCH];
      for (int k = 0; k < NCH; k++) begin
        rot[k]  = $urandom_range(0, 9);
        mode[k] = $urandom_range(0, 2);
      end
      for (int c = 0; c < 40; c++) begin
        logic [NCH*W-1:0] w;
        for (int k = 0; k < NCH; k++) begin
          logic [W-1:0] tw;
          case (mode[k])
            0: tw = W'(rotl('h354, rot[k]));
            1: tw = W'($urandom);
            default: tw = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'(rotl('h354, rot[k]));
          endcase
          w[k*W +: W] = tw;
        end
        tick($urandom_range(0, 3) != 0, w);
      end
    end

    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
